// File: rtl/dm_access_arbiter_pkg.sv
// dm_access_arbiter_pkg: shared types for the data-memory access arbiter.
// Holds the access-size encodings, the FSM state enum, the registered
// command struct and a helper that decides whether a store crosses a
// doubleword boundary.
package dm_access_arbiter_pkg;

    localparam int RNG_64 = 64;

    // Access-size encodings carried on i_core_unit
    localparam logic [1:0] UNIT_B  = 2'd0;
    localparam logic [1:0] UNIT_HW = 2'd1;
    localparam logic [1:0] UNIT_W  = 2'd2;
    localparam logic [1:0] UNIT_DW = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } dm_state_e;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_AUX  = 1'b1
    } dm_owner_e;

    typedef struct packed {
        logic              wr;
        logic [RNG_64-1:0] addr;
        logic [1:0]        unit;
        logic [RNG_64-1:0] wdata;
        dm_owner_e         owner;
    } dm_cmd_t;

    // True when an access of this size starting at byte offset a spills
    // past the end of its 8-byte doubleword.
    function automatic logic unit_crosses(input logic [2:0] a, input logic [1:0] unit);
        logic [3:0] span;
        case (unit)
            UNIT_B:  span = 4'd1;
            UNIT_HW: span = 4'd2;
            UNIT_W:  span = 4'd4;
            default: span = 4'd8;
        endcase
        return (({1'b0, a} + span) > 4'd8);
    endfunction

endpackage

// File: rtl/dm_store_aligner.sv
// dm_store_aligner: combinational store lane placement. Shifts right-
// justified store data into its byte lanes, builds the byte write mask
// and flags stores that would cross a doubleword boundary.
module dm_store_aligner
    import dm_access_arbiter_pkg::*;
(
    input  logic [2:0]  addr_lo_i,
    input  logic [1:0]  unit_i,
    input  logic [63:0] wdata_i,
    output logic [7:0]  wmask_o,
    output logic [63:0] wdata_o,
    output logic        misaligned_o
);

    // Byte-lane mask: one bit per written byte, starting at the byte offset
    always_comb begin
        wmask_o = 8'h00;
        case (unit_i)
            UNIT_B:  wmask_o = 8'h01 << addr_lo_i;
            UNIT_HW: wmask_o = 8'h03 << addr_lo_i;
            UNIT_W:  wmask_o = 8'h0F << addr_lo_i;
            default: wmask_o = 8'hFF;
        endcase
    end

    assign wdata_o      = wdata_i << {addr_lo_i, 3'b000};
    assign misaligned_o = unit_crosses(addr_lo_i, unit_i);

endmodule

// File: rtl/dm_access_arbiter.sv
// dm_access_arbiter: sequences MEM-stage accesses to the 64-bit data memory.
// Optional aux (debug/DMA) doubleword port, arbitration and starve counter
// are built only when DM_ARB_AUX_EN is defined; otherwise the aux inputs
// are ignored and the aux outputs are tied low.
//
// Handshake: a requester raises its req and holds the command stable until
// its done pulse. Core: i_core_req is valid, o_core_stall is "not ready";
// the access completes in the single cycle o_core_done is high (stall low
// there). Aux: o_aux_gnt pulses in the cycle the command is accepted, after
// which aux may change its inputs; o_aux_done pulses with o_aux_rdata valid.
module dm_access_arbiter
    import dm_access_arbiter_pkg::*;
#(
    parameter int DM_LATENCY   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_core_req,
    input  logic        i_core_wr,
    input  logic [63:0] i_core_addr,
    input  logic [1:0]  i_core_unit,
    input  logic [63:0] i_core_wdata,
    output logic        o_core_stall,
    output logic        o_core_done,
    output logic [63:0] o_core_rdata,
    output logic        o_st_misaligned,
    input  logic        i_aux_req,
    input  logic        i_aux_wr,
    input  logic [63:0] i_aux_addr,
    input  logic [63:0] i_aux_wdata,
    output logic        o_aux_gnt,
    output logic        o_aux_done,
    output logic [63:0] o_aux_rdata,
    output logic        o_dm_en,
    output logic        o_dm_we,
    output logic [63:0] o_dm_addr,
    output logic [7:0]  o_dm_wmask,
    output logic [63:0] o_dm_wdata,
    input  logic [63:0] i_dm_rdata,
    output logic [1:0]  o_dbg_state
);

    localparam int LAT_W = $clog2(DM_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(DM_LATENCY);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(1);

    dm_state_e        state_q, state_d;
    dm_cmd_t          cmd_q, cmd_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic             mis_q, mis_d;
    logic [63:0]      core_rdata_q, core_rdata_d;

    logic             core_pick;
    logic             unused_aux;

    // The aligner checks the incoming core command while idle and places
    // the registered command's lanes while issuing.
    logic [2:0]       aln_a;
    logic [1:0]       aln_unit;
    logic [63:0]      aln_wdata_in;
    logic [7:0]       aln_mask;
    logic [63:0]      aln_wdata;
    logic             aln_mis;

    assign aln_a        = (state_q == ST_IDLE) ? i_core_addr[2:0] : cmd_q.addr[2:0];
    assign aln_unit     = (state_q == ST_IDLE) ? i_core_unit      : cmd_q.unit;
    assign aln_wdata_in = (state_q == ST_IDLE) ? i_core_wdata     : cmd_q.wdata;

    dm_store_aligner u_aligner (
        .addr_lo_i    (aln_a),
        .unit_i       (aln_unit),
        .wdata_i      (aln_wdata_in),
        .wmask_o      (aln_mask),
        .wdata_o      (aln_wdata),
        .misaligned_o (aln_mis)
    );

`ifdef DM_ARB_AUX_EN
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_LIMIT);

    logic [STV_W-1:0] starve_q, starve_d;
    logic [63:0]      aux_rdata_q, aux_rdata_d;
    logic             aux_pick;

    // Core wins ties until it has starved a waiting aux STARVE_LIMIT times
    assign aux_pick  = i_aux_req && (!i_core_req || (starve_q == STV_MAX));
    assign core_pick = i_core_req && !aux_pick;

    // Starve counter: counts core grants made while aux is waiting
    always_comb begin
        starve_d = starve_q;
        if (!i_aux_req) begin
            starve_d = '0;
        end else if (state_q == ST_IDLE && aux_pick) begin
            starve_d = '0;
        end else if (state_q == ST_IDLE && core_pick && starve_q != STV_MAX) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    // Aux-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q    <= '0;
            aux_rdata_q <= '0;
        end else begin
            starve_q    <= starve_d;
            aux_rdata_q <= aux_rdata_d;
        end
    end

    assign o_aux_rdata = aux_rdata_q;
    assign unused_aux  = ^i_aux_addr[2:0];
`else
    assign core_pick   = i_core_req;
    assign o_aux_gnt   = 1'b0;
    assign o_aux_done  = 1'b0;
    assign o_aux_rdata = '0;
    assign unused_aux  = ^{i_aux_req, i_aux_wr, i_aux_addr, i_aux_wdata, (STARVE_LIMIT > 0)};
`endif

    // Next-state and output decode; reset forces every pulse and strobe low
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        lat_d           = lat_q;
        mis_d           = mis_q;
        core_rdata_d    = core_rdata_q;
`ifdef DM_ARB_AUX_EN
        aux_rdata_d     = aux_rdata_q;
        o_aux_gnt       = 1'b0;
        o_aux_done      = 1'b0;
`endif
        o_core_done     = 1'b0;
        o_st_misaligned = 1'b0;
        o_dm_en         = 1'b0;
        o_dm_we         = 1'b0;
        o_dm_addr       = '0;
        o_dm_wmask      = '0;
        o_dm_wdata      = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    if (core_pick) begin
                        cmd_d.wr    = i_core_wr;
                        cmd_d.addr  = i_core_addr;
                        cmd_d.unit  = i_core_unit;
                        cmd_d.wdata = i_core_wdata;
                        cmd_d.owner = OWNER_CORE;
                        // A crossing store is rejected without touching memory
                        mis_d       = i_core_wr && aln_mis;
                        state_d     = (i_core_wr && aln_mis) ? ST_DONE : ST_ISSUE;
                    end
`ifdef DM_ARB_AUX_EN
                    else if (aux_pick) begin
                        cmd_d.wr    = i_aux_wr;
                        cmd_d.addr  = {i_aux_addr[63:3], 3'b000};
                        cmd_d.unit  = UNIT_DW;
                        cmd_d.wdata = i_aux_wdata;
                        cmd_d.owner = OWNER_AUX;
                        mis_d       = 1'b0;
                        state_d     = ST_ISSUE;
                        o_aux_gnt   = 1'b1;
                    end
`endif
                end
                ST_ISSUE: begin
                    o_dm_en    = 1'b1;
                    o_dm_we    = cmd_q.wr;
                    o_dm_addr  = {cmd_q.addr[63:3], 3'b000};
                    o_dm_wmask = cmd_q.wr ? aln_mask : 8'h00;
                    o_dm_wdata = cmd_q.wr ? aln_wdata : 64'h0;
                    lat_d      = LAT_LOAD;
                    state_d    = ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_q == LAT_LAST) begin
`ifdef DM_ARB_AUX_EN
                        if (cmd_q.owner == OWNER_AUX) begin
                            aux_rdata_d = i_dm_rdata;
                        end else begin
                            core_rdata_d = i_dm_rdata;
                        end
`else
                        core_rdata_d = i_dm_rdata;
`endif
                        state_d = ST_DONE;
                    end else begin
                        lat_d = lat_q - LAT_W'(1);
                    end
                end
                ST_DONE: begin
                    o_core_done     = (cmd_q.owner == OWNER_CORE);
                    o_st_misaligned = mis_q;
`ifdef DM_ARB_AUX_EN
                    o_aux_done      = (cmd_q.owner == OWNER_AUX);
`endif
                    mis_d           = 1'b0;
                    state_d         = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, command and core read-data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            lat_q        <= '0;
            mis_q        <= 1'b0;
            core_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            lat_q        <= lat_d;
            mis_q        <= mis_d;
            core_rdata_q <= core_rdata_d;
        end
    end

    assign o_core_stall = i_core_req && !(state_q == ST_DONE && cmd_q.owner == OWNER_CORE);
    assign o_core_rdata = core_rdata_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// tb_dm_access_arbiter: directed scoreboard bench for dm_access_arbiter.
module tb_dm_access_arbiter;
  import dm_access_arbiter_pkg::*;

  localparam int LAT  = 2;
  localparam int SLIM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        i_core_req, i_core_wr;
  logic [63:0] i_core_addr, i_core_wdata;
  logic [1:0]  i_core_unit;
  logic        o_core_stall, o_core_done, o_st_misaligned;
  logic [63:0] o_core_rdata;
  logic        i_aux_req, i_aux_wr;
  logic [63:0] i_aux_addr, i_aux_wdata;
  logic        o_aux_gnt, o_aux_done;
  logic [63:0] o_aux_rdata;
  logic        o_dm_en, o_dm_we;
  logic [63:0] o_dm_addr, o_dm_wdata, i_dm_rdata;
  logic [7:0]  o_dm_wmask;
  logic [1:0]  o_dbg_state;

  dm_access_arbiter #(.DM_LATENCY(LAT), .STARVE_LIMIT(SLIM)) dut (
    .clk(clk), .rst(rst),
    .i_core_req(i_core_req), .i_core_wr(i_core_wr), .i_core_addr(i_core_addr),
    .i_core_unit(i_core_unit), .i_core_wdata(i_core_wdata),
    .o_core_stall(o_core_stall), .o_core_done(o_core_done), .o_core_rdata(o_core_rdata),
    .o_st_misaligned(o_st_misaligned),
    .i_aux_req(i_aux_req), .i_aux_wr(i_aux_wr), .i_aux_addr(i_aux_addr), .i_aux_wdata(i_aux_wdata),
    .o_aux_gnt(o_aux_gnt), .o_aux_done(o_aux_done), .o_aux_rdata(o_aux_rdata),
    .o_dm_en(o_dm_en), .o_dm_we(o_dm_we), .o_dm_addr(o_dm_addr), .o_dm_wmask(o_dm_wmask),
    .o_dm_wdata(o_dm_wdata), .i_dm_rdata(i_dm_rdata), .o_dbg_state(o_dbg_state)
  );

  // Memory model: read data is presented only in the cycle exactly LAT
  // cycles after the read strobe; any other cycle returns a poison value.
  logic [LAT-1:0] rd_pipe = '0;
  logic [63:0]    mem_rd_val = '0;
  always @(posedge clk) rd_pipe <= {rd_pipe[LAT-2:0], o_dm_en & ~o_dm_we};
  assign i_dm_rdata = rd_pipe[LAT-1] ? mem_rd_val : 64'hDEAD_BEEF_0BAD_F00D;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic sb_on = 1'b1;
  int stall_low_cyc = -1;

  // {chk_wdata, we, wmask[7:0], addr[63:0], wdata[63:0], cycle[31:0]}
  logic [169:0] exp_issue_q[$];
  // {chk_rdata, misaligned, rdata[63:0], cycle[31:0]}
  logic [97:0]  exp_done_q[$];
  logic [169:0] mon_ei;
  logic [97:0]  mon_ed;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a strobe or done
  always @(negedge clk) begin
    if (sb_on) begin
      if (o_dm_en) begin
        if (exp_issue_q.size() == 0) begin
          chk("unexpected_dm_en", 64'(o_dm_en), 64'd0);
        end else begin
          mon_ei = exp_issue_q.pop_front();
          chk("dm_we", 64'(o_dm_we), 64'(mon_ei[168]));
          chk("dm_wmask", 64'(o_dm_wmask), 64'(mon_ei[167:160]));
          chk("dm_addr", o_dm_addr, mon_ei[159:96]);
          if (mon_ei[169]) chk("dm_wdata", o_dm_wdata, mon_ei[95:32]);
          chk("issue_cycle", 64'(cyc), 64'(mon_ei[31:0]));
        end
      end
      if (o_core_done) begin
        if (exp_done_q.size() == 0) begin
          chk("unexpected_done", 64'(o_core_done), 64'd0);
        end else begin
          mon_ed = exp_done_q.pop_front();
          if (mon_ed[97]) chk("core_rdata", o_core_rdata, mon_ed[95:32]);
          chk("st_misaligned", 64'(o_st_misaligned), 64'(mon_ed[96]));
          chk("done_cycle", 64'(cyc), 64'(mon_ed[31:0]));
        end
      end else if (o_st_misaligned) begin
        chk("stray_misaligned", 64'(o_st_misaligned), 64'd0);
      end
      chk("core_stall", 64'(o_core_stall), 64'(i_core_req && (cyc != stall_low_cyc)));
`ifndef DM_ARB_AUX_EN
      if (i_aux_req) begin
        chk("aux_gnt_off", 64'(o_aux_gnt), 64'd0);
        chk("aux_done_off", 64'(o_aux_done), 64'd0);
        chk("aux_rdata_off", o_aux_rdata, 64'd0);
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_core_done(input string name);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (o_core_done) seen = 1'b1;
    end
    if (!seen) chk(name, 64'd0, 64'd1);
  endtask

  // Called at #1 after a rising edge with the DUT idle; returns likewise.
  task automatic core_op(input logic wr, input logic [63:0] addr, input logic [1:0] unit,
                         input logic [63:0] wdata, input logic [63:0] rd_val, input logic mis,
                         input logic [63:0] exp_addr, input logic [7:0] exp_mask,
                         input logic [63:0] exp_wdata);
    int t;
    i_core_req = 1'b1; i_core_wr = wr; i_core_addr = addr; i_core_unit = unit;
    i_core_wdata = wdata; mem_rd_val = rd_val;
    t = cyc;
    if (!mis) exp_issue_q.push_back({wr, wr, exp_mask, exp_addr, exp_wdata, 32'(t + 1)});
    exp_done_q.push_back({~wr, mis, rd_val, (mis ? 32'(t + 1) : 32'(t + LAT + 2))});
    stall_low_cyc = mis ? t + 1 : t + LAT + 2;
    wait_core_done("core_done_timeout");
    @(posedge clk); #1;
    i_core_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 64'(o_core_stall), 64'd0);
    chk({tag, "_done"}, 64'(o_core_done), 64'd0);
    chk({tag, "_rdata"}, o_core_rdata, 64'd0);
    chk({tag, "_mis"}, 64'(o_st_misaligned), 64'd0);
    chk({tag, "_aux_gnt"}, 64'(o_aux_gnt), 64'd0);
    chk({tag, "_aux_done"}, 64'(o_aux_done), 64'd0);
    chk({tag, "_aux_rdata"}, o_aux_rdata, 64'd0);
    chk({tag, "_dm_en"}, 64'(o_dm_en), 64'd0);
    chk({tag, "_dm_we"}, 64'(o_dm_we), 64'd0);
    chk({tag, "_dm_addr"}, o_dm_addr, 64'd0);
    chk({tag, "_dm_wmask"}, 64'(o_dm_wmask), 64'd0);
    chk({tag, "_dm_wdata"}, o_dm_wdata, 64'd0);
    chk({tag, "_state"}, 64'(o_dbg_state), 64'(ST_IDLE));
  endtask

  // Load interrupted by reset two cycles after it is seen; no done may follow
  task automatic reset_mid_load();
    int t;
    i_core_req = 1'b1; i_core_wr = 1'b0; i_core_addr = 64'h200; i_core_unit = UNIT_DW;
    mem_rd_val = 64'h5555_AAAA_5555_AAAA;
    t = cyc;
    exp_issue_q.push_back({1'b0, 1'b0, 8'h00, 64'h200, 64'h0, 32'(t + 1)});
    stall_low_cyc = -1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; i_core_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    repeat (8) @(posedge clk);
    #1;
  endtask

`ifdef DM_ARB_AUX_EN
  logic [63:0] gexp[6] = '{64'h100, 64'h100, 64'h100, 64'h100, 64'h800, 64'h100};

  task automatic starvation_test();
    int grants;
    int aux_gnts;
    logic in_aux;
    grants = 0; aux_gnts = 0; in_aux = 1'b0;
    sb_on = 1'b0;
    mem_rd_val = 64'hFEED_FACE_CAFE_BEEF;
    i_aux_req = 1'b1; i_aux_wr = 1'b0; i_aux_addr = 64'h805; i_aux_wdata = 64'h0;
    i_core_req = 1'b1; i_core_wr = 1'b0; i_core_addr = 64'h100; i_core_unit = UNIT_DW;
    for (int c = 0; c < 80 && grants < 6; c++) begin
      @(negedge clk);
      if (in_aux) chk("stall_during_aux", 64'(o_core_stall), 64'd1);
      if (o_aux_gnt) aux_gnts++;
      if (o_dm_en) begin
        chk("grant_order", o_dm_addr, gexp[grants]);
        if (o_dm_addr == 64'h800) in_aux = 1'b1;
        grants++;
      end
      if (o_aux_done) begin
        chk("aux_rdata", o_aux_rdata, 64'hFEED_FACE_CAFE_BEEF);
        in_aux = 1'b0;
      end
    end
    chk("grant_count", 64'(grants), 64'd6);
    chk("aux_gnt_count", 64'(aux_gnts), 64'd1);
    wait_core_done("starve_done_timeout");
    @(posedge clk); #1;
    i_core_req = 1'b0; i_aux_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sb_on = 1'b1;
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    i_core_req = 1'b0; i_core_wr = 1'b0; i_core_addr = '0; i_core_unit = UNIT_B; i_core_wdata = '0;
    i_aux_req = 1'b0; i_aux_wr = 1'b0; i_aux_addr = '0; i_aux_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;

`ifndef DM_ARB_AUX_EN
    // Aux held requesting throughout the directed core traffic
    i_aux_req = 1'b1; i_aux_wr = 1'b1; i_aux_addr = 64'h900; i_aux_wdata = 64'h1234;
`endif

    core_op(1'b1, 64'h1003, UNIT_B,  64'hAB, 64'h0, 1'b0, 64'h1000, 8'h08, 64'h0000_0000_AB00_0000);
    core_op(1'b0, 64'h100,  UNIT_DW, 64'h0, 64'h1122_3344_5566_7788, 1'b0, 64'h100, 8'h00, 64'h0);
    core_op(1'b1, 64'h2005, UNIT_W,  64'hDEAD_BEEF, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0);
    core_op(1'b1, 64'h2006, UNIT_HW, 64'hBEEF, 64'h0, 1'b0, 64'h2000, 8'hC0, 64'hBEEF_0000_0000_0000);
    core_op(1'b1, 64'h3007, UNIT_HW, 64'h1234, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0);
    core_op(1'b1, 64'h4004, UNIT_W,  64'hCAFE_F00D, 64'h0, 1'b0, 64'h4000, 8'hF0, 64'hCAFE_F00D_0000_0000);
    core_op(1'b1, 64'h5000, UNIT_DW, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0, 64'h5000, 8'hFF, 64'h0123_4567_89AB_CDEF);
    core_op(1'b1, 64'h5004, UNIT_DW, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1, 64'h0, 8'h00, 64'h0);
    core_op(1'b0, 64'h107,  UNIT_B,  64'h0, 64'hA5A5_5A5A_0F0F_F0F0, 1'b0, 64'h100, 8'h00, 64'h0);
    core_op(1'b1, 64'h0,    UNIT_B,  64'h12, 64'h0, 1'b0, 64'h0, 8'h01, 64'h12);
    repeat (3) @(posedge clk);
    #1;
    core_op(1'b0, 64'h3F8,  UNIT_DW, 64'h0, 64'h0000_0000_0000_0001, 1'b0, 64'h3F8, 8'h00, 64'h0);

    reset_mid_load();
    core_op(1'b0, 64'h8, UNIT_W, 64'h0, 64'h7766_5544_3322_1100, 1'b0, 64'h8, 8'h00, 64'h0);

`ifndef DM_ARB_AUX_EN
    i_aux_req = 1'b0;
`else
    starvation_test();
`endif

    repeat (4) @(posedge clk);
    #1;
    chk("issue_q_drained", 64'(exp_issue_q.size()), 64'd0);
    chk("done_q_drained", 64'(exp_done_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
